// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier write-back path: instruction field
// positions, exception redirect constants and the queued result entry type.
package mult_pkg;

  localparam int RD_MSB = 26;
  localparam int RD_LSB = 22;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] STATUS_REG = 5'd30;
  localparam logic [DATA_W-1:0] EXC_CODE   = 32'd1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Destination register of an instruction word; a bubble (all-zero word) yields r0.
  function automatic logic [ADDR_W-1:0] rd_of(input logic [DATA_W-1:0] ins);
    return (ins == '0) ? '0 : ins[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Result queue between the multiplier and the register-file write port.
// Exposes every slot's address and valid bit so the top can hazard-check them.
module wb_result_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  output wb_entry_t                     head_entry,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
  output logic [DEPTH-1:0]              entry_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DEPTH-1:0] valid;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push at full is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      // Clear before set so a simultaneous push/pop on the same slot at full keeps it valid.
      if (do_pop) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        valid[rd_ptr] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr        <= wr_ptr + PTR_W'(1);
        valid[wr_ptr] <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head_entry  = mem[rd_ptr];
  assign entry_valid = valid;

  always_comb begin
    entry_addr = '0;
    for (int i = 0; i < DEPTH; i++) entry_addr[i] = mem[i].addr;
  end

endmodule

// File: rtl/mult_writeback_unit.sv
// Multiplier write-back: queues products, shares the RF write port with the
// main pipeline, redirects overflow to the status register, raises hazard stalls.
module mult_writeback_unit #(
  parameter int          DEPTH      = 4,
  parameter logic [4:0]  STATUS_REG = mult_pkg::STATUS_REG,
  parameter logic [31:0] EXC_CODE   = mult_pkg::EXC_CODE
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic        mult_result_rdy,
  input  logic [31:0] mult_ins,
  input  logic [31:0] stage_ins_1,
  input  logic [31:0] stage_ins_2,
  input  logic [31:0] stage_ins_3,
  input  logic [4:0]  decode_rs,
  input  logic [4:0]  decode_rt,
  input  logic        wb_busy,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_decode,
  output logic        stall_mult_issue,
  output logic        overflow_err
);

  import mult_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = $clog2(DEPTH) + 3;

  logic [ADDR_W-1:0]             mult_rd_p0;
  logic                          push_req_p0;
  wb_entry_t                     push_entry_p0;
  logic                          bypass_p0;
  logic                          pop_p0;
  logic                          fifo_push_p0;
  wb_entry_t                     head_entry;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [CNT_W-1:0]              fifo_count;
  logic [DEPTH-1:0][ADDR_W-1:0]  fifo_addr;
  logic [DEPTH-1:0]              fifo_valid;
  logic [2:0]                    inflight;
  logic [SUM_W-1:0]              demand;

  // Stage p0: classify the arriving product and pick the write-port source.
  assign mult_rd_p0  = rd_of(mult_ins);
  assign push_req_p0 = mult_result_rdy && (mult_exception || (mult_rd_p0 != '0));

  always_comb begin
    push_entry_p0.addr = mult_rd_p0;
    push_entry_p0.data = mult_result;
    if (mult_exception) begin
      push_entry_p0.addr = STATUS_REG;
      push_entry_p0.data = EXC_CODE;
    end
  end

  assign pop_p0       = !wb_busy && !fifo_empty;
  assign bypass_p0    = !wb_busy && fifo_empty && push_req_p0;
  assign fifo_push_p0 = push_req_p0 && !bypass_p0;

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push        (fifo_push_p0),
    .push_entry  (push_entry_p0),
    .pop         (pop_p0),
    .head_entry  (head_entry),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .entry_addr  (fifo_addr),
    .entry_valid (fifo_valid)
  );

  // Stage p1: registered RF write port and sticky drop flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      overflow_err <= 1'b0;
    end else begin
      rf_we <= pop_p0 || bypass_p0;
      if (pop_p0) begin
        rf_waddr <= head_entry.addr;
        rf_wdata <= head_entry.data;
      end else if (bypass_p0) begin
        rf_waddr <= push_entry_p0.addr;
        rf_wdata <= push_entry_p0.data;
      end
      if (fifo_push_p0 && fifo_full && !pop_p0) overflow_err <= 1'b1;
    end
  end

  function automatic logic reads_reg(input logic [ADDR_W-1:0] dst,
                                     input logic [ADDR_W-1:0] rs,
                                     input logic [ADDR_W-1:0] rt);
    return (dst != '0) && ((dst == rs) || (dst == rt));
  endfunction

  always_comb begin
    stall_decode = 1'b0;
    if (reads_reg(rd_of(stage_ins_1), decode_rs, decode_rt)) stall_decode = 1'b1;
    if (reads_reg(rd_of(stage_ins_2), decode_rs, decode_rt)) stall_decode = 1'b1;
    if (reads_reg(rd_of(stage_ins_3), decode_rs, decode_rt)) stall_decode = 1'b1;
    if (mult_result_rdy && reads_reg(mult_rd_p0, decode_rs, decode_rt)) stall_decode = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i] && reads_reg(fifo_addr[i], decode_rs, decode_rt)) stall_decode = 1'b1;
    end
    // The RF is not write-through, so a write issued last edge is still invisible.
    if (rf_we && reads_reg(rf_waddr, decode_rs, decode_rt)) stall_decode = 1'b1;
  end

  // Every product already in the pipe must still find a slot when it arrives.
  assign inflight = 3'(stage_ins_1 != '0) + 3'(stage_ins_2 != '0)
                  + 3'(stage_ins_3 != '0) + 3'(mult_result_rdy);
  assign demand           = SUM_W'(fifo_count) + SUM_W'(inflight);
  assign stall_mult_issue = (demand >= SUM_W'(DEPTH));

endmodule
